// File: rtl/id_ex_stage_pkg.sv
// rtl/id_ex_stage_pkg.sv - shared opcodes, ALU codes and control-word layout for the ID/EX stage
package id_ex_stage_pkg;

    // Opcodes whose source-register fields are meaningful
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_CTZ    = 7'b1001011;

    // ALUCtl encodings; NOP is the idle code carried by bubbles
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_XOR = 4'b0100;
    localparam logic [3:0] ALU_SLT = 4'b0101;
    localparam logic [3:0] ALU_CTZ = 4'b1000;
    localparam logic [3:0] ALU_NOP = 4'b1111;

    // Control word: {branch, memRead, memtoReg, memWrite, ALUSrc, regWrite, ALUCtl[3:0]}
    localparam int CTRL_W         = 10;
    localparam int CTRL_BRANCH    = 9;
    localparam int CTRL_MEM_READ  = 8;
    localparam int CTRL_MEM_TO_REG = 7;
    localparam int CTRL_MEM_WRITE = 6;
    localparam int CTRL_ALU_SRC   = 5;
    localparam int CTRL_REG_WRITE = 4;

    typedef logic [CTRL_W-1:0] ctrl_word_t;

    // All enables off, ALU idle
    localparam ctrl_word_t CTRL_NOP = {6'b000000, ALU_NOP};

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// rtl/id_ex_stage_hazard_detect.sv - combinational operand-use decode and load-use hazard compare
module hazard_detect
    import id_ex_stage_pkg::*;
#(
    parameter int RA_W = 5
) (
    input  logic            i_id_valid,
    input  logic [6:0]      i_id_opcode,
    input  logic [RA_W-1:0] i_id_rs1,
    input  logic [RA_W-1:0] i_id_rs2,
    input  logic            i_ex_valid,
    input  logic            i_ex_mem_read,
    input  logic [RA_W-1:0] i_ex_rd,
    output logic            o_hazard
);

    logic w_use_rs1;
    logic w_use_rs2;
    logic w_rs1_match;
    logic w_rs2_match;

    // Decide which source fields the ID instruction actually reads
    always_comb begin
        w_use_rs1 = 1'b0;
        w_use_rs2 = 1'b0;
        case (i_id_opcode)
            OP_R, OP_STORE, OP_BRANCH: begin
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
            end
            OP_I, OP_LOAD, OP_CTZ: begin
                w_use_rs1 = 1'b1;
            end
            default: begin
                w_use_rs1 = 1'b0;
                w_use_rs2 = 1'b0;
            end
        endcase
    end

    assign w_rs1_match = (i_id_rs1 == i_ex_rd);
    assign w_rs2_match = (i_id_rs2 == i_ex_rd);

    // x0 is hardwired, so a load targeting it can never feed a consumer
    assign o_hazard = i_id_valid & i_ex_valid & i_ex_mem_read & (i_ex_rd != '0)
                    & ((w_use_rs1 & w_rs1_match) | (w_use_rs2 & w_rs2_match));

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use stall, branch flush and event counters
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int RA_W  = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [6:0]       id_opcode,
    input  logic [RA_W-1:0]  id_rs1,
    input  logic [RA_W-1:0]  id_rs2,
    input  logic [RA_W-1:0]  id_rd,
    input  logic [9:0]       id_ctrl,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [XLEN-1:0]  id_rs1_data,
    input  logic [XLEN-1:0]  id_rs2_data,
    input  logic [XLEN-1:0]  id_imm,
    input  logic             flush,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             ex_valid,
    output logic [9:0]       ex_ctrl,
    output logic [RA_W-1:0]  ex_rs1,
    output logic [RA_W-1:0]  ex_rs2,
    output logic [RA_W-1:0]  ex_rd,
    output logic [XLEN-1:0]  ex_pc,
    output logic [XLEN-1:0]  ex_rs1_data,
    output logic [XLEN-1:0]  ex_rs2_data,
    output logic [XLEN-1:0]  ex_imm,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    logic             r_valid;
    ctrl_word_t       r_ctrl;
    logic [RA_W-1:0]  r_rs1;
    logic [RA_W-1:0]  r_rs2;
    logic [RA_W-1:0]  r_rd;
    logic [XLEN-1:0]  r_pc;
    logic [XLEN-1:0]  r_rs1_data;
    logic [XLEN-1:0]  r_rs2_data;
    logic [XLEN-1:0]  r_imm;
    logic [CNT_W-1:0] r_stall_count;
    logic [CNT_W-1:0] r_flush_count;
    logic             w_hazard;
    logic             w_stall;

    hazard_detect #(
        .RA_W (RA_W)
    ) u_hazard_detect (
        .i_id_valid    (id_valid),
        .i_id_opcode   (id_opcode),
        .i_id_rs1      (id_rs1),
        .i_id_rs2      (id_rs2),
        .i_ex_valid    (r_valid),
        .i_ex_mem_read (r_ctrl[CTRL_MEM_READ]),
        .i_ex_rd       (r_rd),
        .o_hazard      (w_hazard)
    );

    // A flush discards the ID instruction anyway, so it overrides any stall
    assign w_stall     = w_hazard & ~flush;
    assign pc_write    = ~w_stall;
    assign if_id_write = ~w_stall;

    // Pipeline register: flush bubble, then stall bubble, else capture ID
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid    <= 1'b0;
            r_ctrl     <= CTRL_NOP;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_rd       <= '0;
            r_pc       <= '0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_imm      <= '0;
        end else if (flush || w_hazard) begin
            r_valid <= 1'b0;
            r_ctrl  <= CTRL_NOP;
            r_rs1   <= '0;
            r_rs2   <= '0;
            r_rd    <= '0;
        end else begin
            r_valid    <= id_valid;
            r_ctrl     <= id_valid ? id_ctrl : CTRL_NOP;
            r_rs1      <= id_rs1;
            r_rs2      <= id_rs2;
            r_rd       <= id_rd;
            r_pc       <= id_pc;
            r_rs1_data <= id_rs1_data;
            r_rs2_data <= id_rs2_data;
            r_imm      <= id_imm;
        end
    end

    // Saturating event counters; flush takes the credit when both coincide
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_count <= '0;
            r_flush_count <= '0;
        end else if (flush) begin
            if (r_flush_count != '1) begin
                r_flush_count <= r_flush_count + 1'b1;
            end
        end else if (w_hazard) begin
            if (r_stall_count != '1) begin
                r_stall_count <= r_stall_count + 1'b1;
            end
        end
    end

    assign ex_valid    = r_valid;
    assign ex_ctrl     = r_ctrl;
    assign ex_rs1      = r_rs1;
    assign ex_rs2      = r_rs2;
    assign ex_rd       = r_rd;
    assign ex_pc       = r_pc;
    assign ex_rs1_data = r_rs1_data;
    assign ex_rs2_data = r_rs2_data;
    assign ex_imm      = r_imm;
    assign stall_count = r_stall_count;
    assign flush_count = r_flush_count;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - self-checking bench for id_ex_stage
module tb_id_ex_stage;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic [6:0]  id_opcode;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic [4:0]  id_rd;
    logic [9:0]  id_ctrl;
    logic [31:0] id_pc;
    logic [31:0] id_rs1_data;
    logic [31:0] id_rs2_data;
    logic [31:0] id_imm;
    logic        flush;
    logic        pc_write;
    logic        if_id_write;
    logic        ex_valid;
    logic [9:0]  ex_ctrl;
    logic [4:0]  ex_rs1;
    logic [4:0]  ex_rs2;
    logic [4:0]  ex_rd;
    logic [31:0] ex_pc;
    logic [31:0] ex_rs1_data;
    logic [31:0] ex_rs2_data;
    logic [31:0] ex_imm;
    logic [15:0] stall_count;
    logic [15:0] flush_count;

    int tests_run = 0;
    int tests_failed = 0;
    bit chk_en = 1'b0;

    id_ex_stage #(
        .XLEN  (32),
        .RA_W  (5),
        .CNT_W (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .id_valid    (id_valid),
        .id_opcode   (id_opcode),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_rd       (id_rd),
        .id_ctrl     (id_ctrl),
        .id_pc       (id_pc),
        .id_rs1_data (id_rs1_data),
        .id_rs2_data (id_rs2_data),
        .id_imm      (id_imm),
        .flush       (flush),
        .pc_write    (pc_write),
        .if_id_write (if_id_write),
        .ex_valid    (ex_valid),
        .ex_ctrl     (ex_ctrl),
        .ex_rs1      (ex_rs1),
        .ex_rs2      (ex_rs2),
        .ex_rd       (ex_rd),
        .ex_pc       (ex_pc),
        .ex_rs1_data (ex_rs1_data),
        .ex_rs2_data (ex_rs2_data),
        .ex_imm      (ex_imm),
        .stall_count (stall_count),
        .flush_count (flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [9:0] NOP_W  = 10'b0000001111;
    localparam logic [9:0] C_ADD  = 10'b0000010000;
    localparam logic [9:0] C_LW   = 10'b0110110000;
    localparam logic [9:0] C_ADDI = 10'b0000110000;
    localparam logic [9:0] C_SW   = 10'b0001100000;
    localparam logic [9:0] C_CTZ  = 10'b0000011000;
    localparam int CNT_MAX = 65535;

    // Behavioural model of the ID/EX contents
    bit          m_valid;
    logic [9:0]  m_ctrl;
    logic [4:0]  m_rs1, m_rs2, m_rd;
    logic [31:0] m_pc, m_d1, m_d2, m_imm;
    int          m_stall, m_flush;

    function automatic bit reads_rs1(input logic [6:0] op);
        return op == 7'b0110011 || op == 7'b0010011 || op == 7'b0000011 ||
               op == 7'b0100011 || op == 7'b1100011 || op == 7'b1001011;
    endfunction

    function automatic bit reads_rs2(input logic [6:0] op);
        return op == 7'b0110011 || op == 7'b0100011 || op == 7'b1100011;
    endfunction

    // ID needs a register that a load now in EX has not produced yet
    function automatic bit model_hazard();
        bit ex_is_load;
        ex_is_load = m_valid && m_ctrl[8] && m_rd != 5'd0;
        if (!id_valid || !ex_is_load) return 1'b0;
        if (reads_rs1(id_opcode) && id_rs1 == m_rd) return 1'b1;
        if (reads_rs2(id_opcode) && id_rs2 == m_rd) return 1'b1;
        return 1'b0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid <= 1'b0; m_ctrl <= NOP_W;
            m_rs1 <= 0; m_rs2 <= 0; m_rd <= 0;
            m_pc <= 0; m_d1 <= 0; m_d2 <= 0; m_imm <= 0;
            m_stall <= 0; m_flush <= 0;
        end else if (flush) begin
            m_valid <= 1'b0; m_ctrl <= NOP_W;
            m_rs1 <= 0; m_rs2 <= 0; m_rd <= 0;
            m_flush <= (m_flush >= CNT_MAX) ? CNT_MAX : m_flush + 1;
        end else if (model_hazard()) begin
            m_valid <= 1'b0; m_ctrl <= NOP_W;
            m_rs1 <= 0; m_rs2 <= 0; m_rd <= 0;
            m_stall <= (m_stall >= CNT_MAX) ? CNT_MAX : m_stall + 1;
        end else begin
            m_valid <= id_valid;
            m_ctrl  <= id_valid ? id_ctrl : NOP_W;
            m_rs1 <= id_rs1; m_rs2 <= id_rs2; m_rd <= id_rd;
            m_pc <= id_pc; m_d1 <= id_rs1_data; m_d2 <= id_rs2_data; m_imm <= id_imm;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every cycle, away from the active edge, compare DUT against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("pc_write",    32'(pc_write),    32'(!(model_hazard() && !flush)));
            chk("if_id_write", 32'(if_id_write), 32'(!(model_hazard() && !flush)));
            chk("ex_valid",    32'(ex_valid),    32'(m_valid));
            chk("ex_ctrl",     32'(ex_ctrl),     32'(m_ctrl));
            chk("ex_rs1",      32'(ex_rs1),      32'(m_rs1));
            chk("ex_rs2",      32'(ex_rs2),      32'(m_rs2));
            chk("ex_rd",       32'(ex_rd),       32'(m_rd));
            chk("ex_pc",       ex_pc,            m_pc);
            chk("ex_rs1_data", ex_rs1_data,      m_d1);
            chk("ex_rs2_data", ex_rs2_data,      m_d2);
            chk("ex_imm",      ex_imm,           m_imm);
            chk("stall_count", 32'(stall_count), 32'(m_stall));
            chk("flush_count", 32'(flush_count), 32'(m_flush));
        end
    end

    task automatic set_in(input logic v, input logic [6:0] op, input logic [4:0] r1,
                          input logic [4:0] r2, input logic [4:0] rd, input logic [9:0] c,
                          input logic [31:0] pc, input logic [31:0] d1, input logic [31:0] d2,
                          input logic [31:0] imm);
        id_valid = v; id_opcode = op; id_rs1 = r1; id_rs2 = r2; id_rd = rd;
        id_ctrl = c; id_pc = pc; id_rs1_data = d1; id_rs2_data = d2; id_imm = imm;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_lw5(input logic [31:0] pc);
        set_in(1'b1, 7'b0000011, 5'd1, 5'd0, 5'd5, C_LW, pc, 32'h100, 32'h0, 32'h8);
        tick();
    endtask

    initial begin
        rst = 1'b0;
        flush = 1'b0;
        set_in(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, NOP_W, 0, 0, 0, 0);
        #1 rst = 1'b1;
        #1 chk_en = 1'b1;
        // Reset with random inputs
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                   10'($urandom), $urandom, $urandom, $urandom, $urandom);
            flush = 1'($urandom);
            tick();
        end
        rst = 1'b0;
        flush = 1'b0;
        set_in(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, NOP_W, 0, 0, 0, 0);
        #1;
        chk("rst_ex_valid", 32'(ex_valid), 32'd0);
        chk("rst_ex_ctrl",  32'(ex_ctrl),  32'h00F);
        chk("rst_stall",    32'(stall_count), 32'd0);
        chk("rst_flush",    32'(flush_count), 32'd0);
        chk("rst_pc_write", 32'(pc_write), 32'd1);
        tick();

        // Pass-through ADD x3,x1,x2
        set_in(1'b1, 7'b0110011, 5'd1, 5'd2, 5'd3, C_ADD, 32'h40, 32'd5, 32'd7, 32'h0);
        tick();
        chk("add_valid", 32'(ex_valid), 32'd1);
        chk("add_rd",    32'(ex_rd),    32'd3);
        chk("add_pc",    ex_pc,         32'h40);
        chk("add_d1",    ex_rs1_data,   32'd5);
        chk("add_d2",    ex_rs2_data,   32'd7);
        chk("add_ctrl",  32'(ex_ctrl),  32'h010);

        // Load-use: LW x5 then ADD x6,x5,x1
        issue_lw5(32'h44);
        set_in(1'b1, 7'b0110011, 5'd5, 5'd1, 5'd6, C_ADD, 32'h48, 32'd11, 32'd12, 32'h0);
        #1;
        chk("lu_pc_write", 32'(pc_write),    32'd0);
        chk("lu_ifid",     32'(if_id_write), 32'd0);
        tick();
        chk("lu_bubble_valid", 32'(ex_valid), 32'd0);
        chk("lu_bubble_ctrl",  32'(ex_ctrl),  32'h00F);
        chk("lu_stall",        32'(stall_count), 32'd1);
        chk("lu_release",      32'(pc_write), 32'd1);
        tick();
        chk("lu_add_valid", 32'(ex_valid), 32'd1);
        chk("lu_add_rd",    32'(ex_rd),    32'd6);

        // LW x0 then ADD x6,x0,x1: no stall
        set_in(1'b1, 7'b0000011, 5'd1, 5'd0, 5'd0, C_LW, 32'h4C, 32'h0, 32'h0, 32'h4);
        tick();
        set_in(1'b1, 7'b0110011, 5'd0, 5'd1, 5'd6, C_ADD, 32'h50, 32'd0, 32'd3, 32'h0);
        #1;
        chk("x0_no_stall", 32'(pc_write), 32'd1);
        tick();

        // LW x5 then ADDI x7,x1 with rs2 field = 5: no stall
        issue_lw5(32'h54);
        set_in(1'b1, 7'b0010011, 5'd1, 5'd5, 5'd7, C_ADDI, 32'h58, 32'd9, 32'd0, 32'h5);
        #1;
        chk("addi_no_stall", 32'(pc_write), 32'd1);
        tick();

        // LW x5 then SW x5 (rs2 read): stall
        issue_lw5(32'h5C);
        set_in(1'b1, 7'b0100011, 5'd1, 5'd5, 5'd0, C_SW, 32'h60, 32'd1, 32'd2, 32'h10);
        #1;
        chk("sw_stall", 32'(pc_write), 32'd0);
        tick();
        tick();

        // LW x5 then CTZ x8,x5: stall
        issue_lw5(32'h64);
        set_in(1'b1, 7'b1001011, 5'd5, 5'd0, 5'd8, C_CTZ, 32'h68, 32'd0, 32'd0, 32'h0);
        #1;
        chk("ctz_stall", 32'(pc_write), 32'd0);
        tick();
        tick();
        chk("stall_total", 32'(stall_count), 32'd3);

        // Invalid ID forces NOP control
        set_in(1'b0, 7'b0000011, 5'd1, 5'd0, 5'd5, C_LW, 32'h6C, 32'h0, 32'h0, 32'h0);
        tick();
        chk("inv_valid", 32'(ex_valid), 32'd0);
        chk("inv_ctrl",  32'(ex_ctrl),  32'h00F);

        // Flush beats a simultaneous load-use hazard
        issue_lw5(32'h70);
        set_in(1'b1, 7'b0110011, 5'd5, 5'd1, 5'd6, C_ADD, 32'h74, 32'd1, 32'd1, 32'h0);
        flush = 1'b1;
        #1;
        chk("fl_pc_write", 32'(pc_write), 32'd1);
        tick();
        flush = 1'b0;
        chk("fl_valid", 32'(ex_valid),    32'd0);
        chk("fl_count", 32'(flush_count), 32'd1);
        chk("fl_stall", 32'(stall_count), 32'd3);

        // Flush counter saturation
        flush = 1'b1;
        for (int i = 0; i < 65539; i++) tick();
        flush = 1'b0;
        chk("sat_flush", 32'(flush_count), 32'hFFFF);
        chk("sat_stall", 32'(stall_count), 32'd3);

        // Reset asserted mid-stall
        issue_lw5(32'h80);
        set_in(1'b1, 7'b0110011, 5'd5, 5'd1, 5'd6, C_ADD, 32'h84, 32'd1, 32'd1, 32'h0);
        #1;
        chk("mid_pre_stall", 32'(pc_write), 32'd0);
        rst = 1'b1;
        #1;
        chk("mid_pc_write", 32'(pc_write),    32'd1);
        chk("mid_ifid",     32'(if_id_write), 32'd1);
        chk("mid_valid",    32'(ex_valid),    32'd0);
        chk("mid_flush",    32'(flush_count), 32'd0);
        chk("mid_stall",    32'(stall_count), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        tick();

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
